mult_share_arb: RTL and testbench
=================================

MULT_SHARE_ARB -- requirements
Module: mult_share_arb

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the multiplier.
REQ-002 Parameter IWIDTH, default 18: signed operand width, 1..18; operands are sign-extended to 18 bits before the multiplier.
REQ-003 Parameter RDEPTH, default 4: result FIFO depth, power of two, at least 4.
REQ-004 clk  in  1: the only clock; all state updates on its rising edge.
REQ-005 rst  in  1: reset, synchronous and active-high.
REQ-006 req_valid  in  NREQ: per-requester operand-pair valid.
REQ-007 req_ready  out  NREQ: per-requester accept; at most one bit high per cycle.
REQ-008 req_a  in  NREQ*IWIDTH: signed operand A per requester; requester i occupies slice [i*IWIDTH +: IWIDTH].
REQ-009 req_b  in  NREQ*IWIDTH: signed operand B per requester, same packing as req_a.
REQ-010 res_valid  out  1: result available at the FIFO head.
REQ-011 res_ready  in  1: downstream accepts the result.
REQ-012 res_id  out  clog2(NREQ): index of the requester that owns the result.
REQ-013 res_data  out  36: full signed 18x18 product.
REQ-014 busy  out  1: high while any product is in flight or the FIFO is non-empty.

Function
REQ-015 Transfer rule: a transfer occurs in a cycle when req_valid[i] and req_ready[i] are both high; a requester holds req_a, req_b and req_valid stable until that happens.
REQ-016 Round-robin grant:
- Search starts at the pointer ptr (0 after reset).
- The granted requester is the first valid one in order ptr, ptr+1, ... with wrap-around modulo NREQ.
- After each transfer, ptr becomes grant+1 modulo NREQ.
- ptr does not change in a cycle with no transfer.
REQ-017 Issue condition: req_ready is asserted only when fifo_count + inflight < RDEPTH; inflight is 1 if a product is in the multiplier pipeline, otherwise 0.
REQ-018 req_ready is purely a function of registered state and the current req_valid; it does not depend on res_ready.
REQ-019 Datapath: the transferred operands go straight to one mult18x18_1c instance with en tied high and its reset driven by rst; the product is registered with one cycle of latency.
REQ-020 The requester id and a valid bit travel alongside the multiplier in a 1-stage shadow register.
REQ-021 Arithmetic: res_data is the exact two's-complement product of the sign-extended operands; there is no rounding or truncation.
REQ-022 Latency: an operand pair transferred in cycle C reaches the FIFO at the end of cycle C+1. It is presented on res_* in cycle C+2 if the FIFO was otherwise empty.
REQ-023 Throughput: with res_ready held high, one transfer is sustained every cycle indefinitely.
REQ-024 FIFO: results pop in issue order; a pop occurs when res_valid and res_ready are both high.
REQ-025 A push and a pop in the same cycle leave the FIFO count unchanged.
REQ-026 Full FIFO: a push is never lost, because REQ-017 guarantees free space.
REQ-027 Empty FIFO: res_valid is low; res_data and res_id hold their last value and are don't-care.
REQ-028 Starvation bound: any requester holding req_valid is granted within NREQ transfers.

Reset
REQ-029 While rst is high: req_ready=0, res_valid=0, busy=0, res_id=0, res_data=0, ptr=0, the shadow valid is cleared and the FIFO is emptied.
REQ-030 A reset asserted mid-operation discards all in-flight and queued results.
REQ-031 The first grant is possible in the first cycle in which rst is low.

Structure
REQ-032 The following belong in the shared FFT/SDR package: the constant MULT_W=18, the constant PROD_W=36, and the result record type (id, data).
REQ-033 The round-robin grant logic is one sub-module, rr_arbiter, with inputs (clk, rst, req, advance) and outputs (grant_onehot, grant_idx).
REQ-034 The result FIFO is inline logic; mult18x18_1c is instantiated unchanged.

Verification
REQ-035 Single request: requester 2 presents a=3, b=-5 in cycle 0 -> res_valid in cycle 2 with res_id=2 and res_data=-15; busy is low in cycle 3.
REQ-036 Extremes: a=-131072, b=-131072 -> res_data=17179869184; a=131071, b=-131072 -> res_data=-17179738112.
REQ-037 Fairness: all 4 requesters valid continuously with res_ready=1 -> grants in order 0,1,2,3,0,... one per cycle, and res_id follows the same order two cycles later.
REQ-038 Backpressure: res_ready=0 while all requesters are valid -> exactly 4 transfers, then req_ready=0. Raising res_ready resumes transfers with no result lost or duplicated; a scoreboard checks order.
REQ-039 Reset mid-stream: rst pulsed for 1 cycle while 3 results are queued -> res_valid=0 the cycle after; no stale result appears afterwards; the next grant goes to requester 0 if it is valid.
REQ-040 Simultaneous push and pop at full occupancy minus one -> fifo_count unchanged; 1000-cycle random valid/ready stress compared against a reference model.

Source files
------------

// File: rtl/mult_share_arb_pkg.sv
// Shared FFT/SDR definitions for the shared-multiplier arbiter.
// Provides the multiplier operand/product widths, the result record
// stored in the result FIFO, and an operand sign-extension helper.
package mult_share_arb_pkg;

    localparam int unsigned MULT_W = 18;
    localparam int unsigned PROD_W = 36;
    // Widest requester index a result record can carry.
    localparam int unsigned ID_W   = 8;

    typedef struct packed {
        logic [ID_W-1:0]          id;
        logic signed [PROD_W-1:0] data;
    } result_t;

    // Sign-extend a w-bit value (held in the low bits of raw) to MULT_W bits.
    function automatic logic [MULT_W-1:0] sext_operand(input logic [MULT_W-1:0] raw,
                                                        input int unsigned       w);
        logic [MULT_W-1:0] r;
        r = raw;
        for (int unsigned i = 0; i < MULT_W; i++) begin
            if (i >= w) begin
                r[i] = raw[w-1];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_share_arb_if.sv
// Requester/result bus of mult_share_arb.
//   req_valid/req_ready : per-requester handshake (one-hot ready)
//   req_a/req_b         : packed signed operands, requester i at [i*IWIDTH +: IWIDTH]
//   res_valid/res_ready : result FIFO head handshake
//   res_id/res_data     : owning requester and full 36-bit product
//   busy                : product in flight or FIFO non-empty
interface mult_share_arb_if
    import mult_share_arb_pkg::*;
#(
    parameter  int unsigned NREQ   = 4,
    parameter  int unsigned IWIDTH = 18,
    localparam int unsigned IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
);
    logic [NREQ-1:0]          req_valid;
    logic [NREQ-1:0]          req_ready;
    logic [NREQ*IWIDTH-1:0]   req_a;
    logic [NREQ*IWIDTH-1:0]   req_b;
    logic                     res_valid;
    logic                     res_ready;
    logic [IDW-1:0]           res_id;
    logic signed [PROD_W-1:0] res_data;
    logic                     busy;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_id, res_data, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_id, res_data, busy
    );
endinterface

// File: rtl/mult18x18_1c.sv
// Signed 18x18 multiplier with one registered output stage.
//   clk, rst : clock, synchronous active-high reset (clears p)
//   en       : capture enable
//   a, b     : signed 18-bit operands
//   p        : registered signed 36-bit product
module mult18x18_1c (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic signed [17:0] a,
    input  logic signed [17:0] b,
    output logic signed [35:0] p
);
    logic signed [35:0] p_q, p_d;

    always_comb begin
        p_d = p_q;
        if (en) begin
            p_d = a * b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end

    assign p = p_q;
endmodule

// File: rtl/mult_share_arb_rr_arbiter.sv
// Round-robin arbiter. Search starts at ptr; the first asserted req in
// order ptr, ptr+1, ... (wrapping) is granted. When advance is high the
// pointer moves to grant+1, otherwise it holds.
//   clk, rst     : clock, synchronous active-high reset (ptr -> 0)
//   req          : request vector (already qualified by the caller)
//   advance      : a transfer happened on the current grant
//   grant_onehot : one-hot grant, zero when no request
//   grant_idx    : index of the granted requester
module rr_arbiter #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant_onehot,
    output logic [IDW-1:0]  grant_idx
);
    logic [IDW-1:0] ptr_q, ptr_d;

    always_comb begin
        int unsigned idx;
        logic        found;
        grant_onehot = '0;
        grant_idx    = '0;
        found        = 1'b0;
        idx          = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = 32'(ptr_q) + i;
            if (idx >= NREQ) begin
                idx = idx - NREQ;
            end
            if (!found && req[idx]) begin
                found             = 1'b1;
                grant_onehot[idx] = 1'b1;
                grant_idx         = IDW'(idx);
            end
        end
    end

    always_comb begin
        int unsigned nxt;
        ptr_d = ptr_q;
        nxt   = 32'(grant_idx) + 1;
        if (advance) begin
            ptr_d = (nxt >= NREQ) ? '0 : IDW'(nxt);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/mult_share_arb.sv
// Shares one registered 18x18 multiplier among NREQ requesters.
// A round-robin arbiter grants one operand pair per cycle while the result
// FIFO plus the in-flight product still fit in RDEPTH entries; products
// return tagged with the requester index, in issue order.
//   clk, rst : clock, synchronous active-high reset
//   bus      : requester/result bus (slave side), see mult_share_arb_if
module mult_share_arb
    import mult_share_arb_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned IWIDTH = 18,
    parameter int unsigned RDEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mult_share_arb_if.slave       bus
);
    localparam int unsigned IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned PW  = $clog2(RDEPTH);
    localparam int unsigned CW  = PW + 1;

    logic [NREQ-1:0]          arb_req;
    logic [NREQ-1:0]          grant_onehot;
    logic [IDW-1:0]           grant_idx;
    logic                     can_issue;
    logic                     transfer;
    logic [MULT_W-1:0]        op_a, op_b;
    logic signed [PROD_W-1:0] prod;

    logic                     sh_valid_q, sh_valid_d;
    logic [IDW-1:0]           sh_id_q, sh_id_d;

    result_t                  mem_q [RDEPTH];
    result_t                  mem_d [RDEPTH];
    logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic                     push, pop, fifo_nonempty;
    result_t                  head;
    logic                     unused_id_bits;

    // Reserve a FIFO slot for the product still in the multiplier so a
    // push can never find the FIFO full.
    assign can_issue = (32'(count_q) + 32'(sh_valid_q)) < RDEPTH;
    assign arb_req   = rst ? '0 : (bus.req_valid & {NREQ{can_issue}});
    assign transfer  = |grant_onehot;

    rr_arbiter #(
        .NREQ(NREQ)
    ) u_arb (
        .clk          (clk),
        .rst          (rst),
        .req          (arb_req),
        .advance      (transfer),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx)
    );

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (32'(grant_idx) == i) begin
                op_a = sext_operand(MULT_W'(bus.req_a[i*IWIDTH +: IWIDTH]), IWIDTH);
                op_b = sext_operand(MULT_W'(bus.req_b[i*IWIDTH +: IWIDTH]), IWIDTH);
            end
        end
    end

    mult18x18_1c u_mult (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .a   ($signed(op_a)),
        .b   ($signed(op_b)),
        .p   (prod)
    );

    // Shadow stage tracking which product the multiplier register holds.
    always_comb begin
        sh_valid_d = transfer;
        sh_id_d    = grant_idx;
    end

    assign fifo_nonempty = (count_q != '0);
    assign push          = sh_valid_q;
    assign pop           = fifo_nonempty && bus.res_ready && !rst;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = '{id: ID_W'(sh_id_q), data: prod};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_valid_q <= 1'b0;
            sh_id_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int unsigned i = 0; i < RDEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            sh_valid_q <= sh_valid_d;
            sh_id_q    <= sh_id_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            mem_q      <= mem_d;
        end
    end

    assign head           = mem_q[rd_ptr_q];
    assign unused_id_bits = ^head.id;

    // Outputs are forced to their idle values for the whole reset cycle.
    always_comb begin
        bus.req_ready = grant_onehot;
        bus.res_valid = fifo_nonempty && !rst;
        bus.res_id    = rst ? '0 : IDW'(head.id);
        bus.res_data  = rst ? '0 : head.data;
        bus.busy      = !rst && (sh_valid_q || fifo_nonempty);
    end
endmodule

// File: tb/tb_mult_share_arb.sv
module tb_mult_share_arb;
    import mult_share_arb_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IW   = 18;
    localparam int unsigned RD   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mult_share_arb_if #(.NREQ(NREQ), .IWIDTH(IW)) bus ();

    mult_share_arb #(
        .NREQ   (NREQ),
        .IWIDTH (IW),
        .RDEPTH (RD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int     id;
        longint data;
    } rec_t;

    rec_t            q[$];
    bit              m_infl = 1'b0;
    rec_t            m_rec;
    int              m_ptr = 0;
    logic [NREQ-1:0] m_xfer = '0;

    function automatic longint get_a(input int i);
        logic signed [IW-1:0] v;
        v = bus.req_a[i*IW +: IW];
        return longint'(v);
    endfunction

    function automatic longint get_b(input int i);
        logic signed [IW-1:0] v;
        v = bus.req_b[i*IW +: IW];
        return longint'(v);
    endfunction

    task automatic set_op(input int i, input int a, input int b);
        bus.req_a[i*IW +: IW] = IW'(a);
        bus.req_b[i*IW +: IW] = IW'(b);
    endtask

    // Checks the current cycle against the model at the falling edge, then
    // advances the model across the rising edge. Returns at posedge+1.
    task automatic model_cycle();
        logic [NREQ-1:0] exp_ready;
        int g;
        int idx;
        @(negedge clk);
        exp_ready = '0;
        g = -1;
        if (!rst && (q.size() + int'(m_infl)) < RD) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_ptr + k) % NREQ;
                if (g < 0 && bus.req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
        check("res_valid", 64'(bus.res_valid), 64'(!rst && q.size() != 0));
        check("busy", 64'(bus.busy), 64'(!rst && (m_infl || q.size() != 0)));
        if (rst) begin
            check("rst_res_id", 64'(bus.res_id), 64'(0));
            check("rst_res_data", 64'($signed(bus.res_data)), 64'(0));
        end else if (q.size() != 0) begin
            check("res_id", 64'(bus.res_id), 64'(q[0].id));
            check("res_data", 64'($signed(bus.res_data)), q[0].data);
        end
        if (rst) begin
            q.delete();
            m_infl = 1'b0;
            m_ptr  = 0;
            m_xfer = '0;
        end else begin
            if (q.size() != 0 && bus.res_ready) void'(q.pop_front());
            if (m_infl) q.push_back(m_rec);
            m_xfer = exp_ready;
            if (g >= 0) begin
                m_rec.id   = g;
                m_rec.data = get_a(g) * get_b(g);
                m_ptr      = (g + 1) % NREQ;
                m_infl     = 1'b1;
            end else begin
                m_infl = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        model_cycle();
        rst = 1'b0;
    endtask

    // ---------------- directed single-request vectors ----------------
    typedef struct {
        int     id;
        int     a;
        int     b;
        longint exp;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int nxfer;
        int bound;

        vecs[0] = '{id: 2, a: 3,       b: -5,      exp: -64'sd15};
        vecs[1] = '{id: 0, a: -131072, b: -131072, exp: 64'sd17179869184};
        vecs[2] = '{id: 1, a: 131071,  b: -131072, exp: -64'sd17179738112};
        vecs[3] = '{id: 3, a: 0,       b: 7,       exp: 64'sd0};
        vecs[4] = '{id: 1, a: -1,      b: -1,      exp: 64'sd1};
        vecs[5] = '{id: 0, a: 100,     b: 200,     exp: 64'sd20000};

        rst           = 1'b1;
        bus.req_valid = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b1;
        for (int i = 0; i < NREQ; i++) set_op(i, i + 1, -(i + 3));
        @(posedge clk);
        #1;
        #2;
        check("reset_req_ready", 64'(bus.req_ready), 64'(0));
        check("reset_res_valid", 64'(bus.res_valid), 64'(0));
        check("reset_busy", 64'(bus.busy), 64'(0));
        model_cycle();

        // Fairness: first cycle out of reset grants requester 0, then rotates.
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            #2;
            check("fair_grant", 64'(bus.req_ready), 64'(1 << (k % 4)));
            if (k >= 2) begin
                check("fair_res_valid", 64'(bus.res_valid), 64'(1));
                check("fair_res_id", 64'(bus.res_id), 64'((k - 2) % 4));
            end
            model_cycle();
        end
        bus.req_valid = '0;
        for (int k = 0; k < 4; k++) model_cycle();

        // Table vectors: latency, arithmetic extremes, busy drop.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            set_op(vecs[v].id, vecs[v].a, vecs[v].b);
            bus.req_valid = NREQ'(1 << vecs[v].id);
            #2;
            check("vec_grant", 64'(bus.req_ready), 64'(1 << vecs[v].id));
            model_cycle();
            bus.req_valid = '0;
            #2;
            check("vec_c1_res_valid", 64'(bus.res_valid), 64'(0));
            check("vec_c1_busy", 64'(bus.busy), 64'(1));
            model_cycle();
            #2;
            check("vec_c2_res_valid", 64'(bus.res_valid), 64'(1));
            check("vec_c2_res_id", 64'(bus.res_id), 64'(vecs[v].id));
            check("vec_c2_res_data", 64'($signed(bus.res_data)), vecs[v].exp);
            model_cycle();
            #2;
            check("vec_c3_busy", 64'(bus.busy), 64'(0));
            model_cycle();
        end

        // Backpressure: exactly RDEPTH transfers, then stall, then drain.
        do_reset();
        bus.res_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_op(i, 1000 * (i + 1), -7 - i);
        bus.req_valid = '1;
        nxfer = 0;
        for (int k = 0; k < 8; k++) begin
            #2;
            if (bus.req_ready != '0) nxfer++;
            model_cycle();
        end
        check("bp_transfers", 64'(nxfer), 64'(4));
        #2;
        check("bp_stalled", 64'(bus.req_ready), 64'(0));
        bus.res_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            model_cycle();
            for (int i = 0; i < NREQ; i++) if (m_xfer[i]) set_op(i, k * 13 - i, 5 + k);
        end
        bus.req_valid = '0;
        for (int k = 0; k < 8; k++) model_cycle();

        // Reset with three results queued.
        do_reset();
        bus.res_ready = 1'b0;
        set_op(1, 9, 9);
        bus.req_valid = 4'b0010;
        for (int k = 0; k < 3; k++) model_cycle();
        bus.req_valid = '0;
        for (int k = 0; k < 2; k++) model_cycle();
        #2;
        check("rstmid_queued", 64'(bus.res_valid), 64'(1));
        rst = 1'b1;
        bus.req_valid = '1;
        set_op(0, 11, -3);
        model_cycle();
        rst = 1'b0;
        #2;
        check("rstmid_res_valid", 64'(bus.res_valid), 64'(0));
        check("rstmid_grant0", 64'(bus.req_ready), 64'(1));
        model_cycle();
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        for (int k = 0; k < 6; k++) model_cycle();

        // Simultaneous push and pop with RDEPTH-1 results queued.
        do_reset();
        bus.res_ready = 1'b0;
        set_op(1, -77, 33);
        bus.req_valid = 4'b0010;
        for (int k = 0; k < 4; k++) model_cycle();
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        #2;
        check("pp_count_before", 64'(dut.count_q), 64'(3));
        model_cycle();
        #2;
        check("pp_count_after", 64'(dut.count_q), 64'(3));
        for (int k = 0; k < 6; k++) model_cycle();

        // Random stress against the model.
        do_reset();
        for (int k = 0; k < 1000; k++) begin
            bus.res_ready = ($urandom_range(0, 3) != 0);
            model_cycle();
            for (int i = 0; i < NREQ; i++) begin
                if (m_xfer[i] || !bus.req_valid[i]) begin
                    bus.req_valid[i] = ($urandom_range(0, 1) == 1);
                    set_op(i, int'($urandom_range(0, 262143)) - 131072,
                              int'($urandom_range(0, 262143)) - 131072);
                end
            end
        end
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        bound = 0;
        while ((q.size() != 0 || m_infl) && bound < 20) begin
            model_cycle();
            bound++;
        end
        #2;
        check("stress_drained_busy", 64'(bus.busy), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
